// File: rtl/counter_bank.sv
// Multi-channel prescaled free-running counter bank with per-channel wrap pulses and a coherent snapshot.
// Define COUNTER_BANK_SATURATE_EN to make the counters saturate at their limits instead of wrapping.
module counter_bank #(
  parameter int CHANNELS  = 2,
  parameter int BITS      = 4,
  parameter int LOG2DELAY = 26
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CHANNELS-1:0]      en,
  input  logic [CHANNELS-1:0]      dir,
  input  logic [CHANNELS-1:0]      clr,
  input  logic                     snap,
  output logic [CHANNELS*BITS-1:0] led,
  output logic [CHANNELS-1:0]      wrap,
  output logic [CHANNELS*BITS-1:0] snap_q,
  output logic                     snap_vld
);

  localparam int W = BITS + LOG2DELAY;
  localparam logic [W-1:0] ALL_ONES = '1;
  localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;
    logic         wrap_q;
    logic         wrap_nxt;

    // clr outranks en and never raises a wrap pulse.
    always_comb begin
      cnt_nxt  = cnt;
      wrap_nxt = 1'b0;
      if (clr[i]) begin
        cnt_nxt = '0;
      end else if (en[i]) begin
        if (!dir[i]) begin
`ifdef COUNTER_BANK_SATURATE_EN
          if (cnt != ALL_ONES) begin
            cnt_nxt  = cnt + ONE;
            wrap_nxt = (cnt_nxt == ALL_ONES);
          end
`else
          cnt_nxt  = cnt + ONE;
          wrap_nxt = (cnt == ALL_ONES);
`endif
        end else begin
`ifdef COUNTER_BANK_SATURATE_EN
          if (cnt != '0) begin
            cnt_nxt  = cnt - ONE;
            wrap_nxt = (cnt_nxt == '0);
          end
`else
          cnt_nxt  = cnt - ONE;
          wrap_nxt = (cnt == '0);
`endif
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt    <= '0;
        wrap_q <= 1'b0;
      end else begin
        cnt    <= cnt_nxt;
        wrap_q <= wrap_nxt;
      end
    end

    assign led[i*BITS +: BITS] = cnt[W-1:LOG2DELAY];
    assign wrap[i]             = wrap_q;
  end

  // Capture uses the pre-update led value so all channels are sampled on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_q   <= '0;
      snap_vld <= 1'b0;
    end else begin
      snap_vld <= snap;
      if (snap) snap_q <= led;
    end
  end

endmodule

// File: tb/tb_counter_bank.sv
// Scoreboard bench for counter_bank (CHANNELS=2, BITS=4, LOG2DELAY=2, W=6).
// Stimulus pushes timed expectations and snapshot values; a monitor process pops and compares them.
module tb_counter_bank;

  logic       clk;
  logic       rst_n;
  logic [1:0] en;
  logic [1:0] dir;
  logic [1:0] clr;
  logic       snap;
  logic [7:0] led;
  logic [1:0] wrap;
  logic [7:0] snap_q;
  logic       snap_vld;

  counter_bank #(.CHANNELS(2), .BITS(4), .LOG2DELAY(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .snap(snap),
    .led(led), .wrap(wrap), .snap_q(snap_q), .snap_vld(snap_vld)
  );

  typedef struct {
    int         due;
    int         kind;
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t       pending[$];
  logic [7:0] snap_exp[$];
  int         cyc = 0;
  int         assertions = 0;
  int         failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] actualOf(input int kind);
    case (kind)
      0:       return led;
      1:       return {6'b0, wrap};
      2:       return {7'b0, snap_vld};
      default: return snap_q;
    endcase
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int i = pending.size() - 1; i >= 0; i--) begin
      if (pending[i].due == cyc) begin
        checkOutput(pending[i].name, actualOf(pending[i].kind), pending[i].exp);
        pending.delete(i);
      end
    end
    if (snap_vld === 1'b1) begin
      if (snap_exp.size() == 0) begin
        assertions++;
        failures++;
        $display("[TB] FAIL snap_unexpected at cycle %0d: got snap_vld 1, expected 0", cyc);
      end else begin
        checkOutput("snap_q_on_vld", snap_q, snap_exp.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic [1:0] e, input logic [1:0] d,
                               input logic [1:0] c, input logic s);
    rst_n = r;
    en    = e;
    dir   = d;
    clr   = c;
    snap  = s;
  endtask

  task automatic expectAt(input string name, input int kind, input logic [7:0] exp, input int delay);
    chk_t c;
    c.due  = cyc + delay;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    pending.push_back(c);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    step(2);

    // Reset values
    expectAt("rst_led", 0, 8'h00, 1);
    expectAt("rst_wrap", 1, 8'h00, 1);
    expectAt("rst_snap_vld", 2, 8'h00, 1);
    expectAt("rst_snap_q", 3, 8'h00, 1);
    step(1);

`ifndef COUNTER_BANK_SATURATE_EN
    // Both channels up: led steps every 4 cycles, wrap after 64
    applyStimulus(1'b1, 2'b11, 2'b00, 2'b00, 1'b0);
    expectAt("up_led_3", 0, 8'h00, 3);
    expectAt("up_led_4", 0, 8'h11, 4);
    expectAt("up_wrap_63", 1, 8'h00, 63);
    expectAt("up_wrap_64", 1, 8'h03, 64);
    expectAt("up_led_64", 0, 8'h00, 64);
    expectAt("up_wrap_65", 1, 8'h00, 65);
    step(64);
    applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
    step(2);
`endif

    // Channel 0 only for 20 cycles
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    step(1);
    applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
    expectAt("en01_led_20", 0, 8'h05, 20);
    expectAt("en01_wrap_20", 1, 8'h00, 20);
    step(20);

`ifndef COUNTER_BANK_SATURATE_EN
    // Down from zero wraps to all-ones, then an immediate reversal wraps back
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    step(1);
    applyStimulus(1'b1, 2'b01, 2'b01, 2'b00, 1'b0);
    expectAt("down_led", 0, 8'h0F, 1);
    expectAt("down_wrap", 1, 8'h01, 1);
    step(1);
    applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
    expectAt("rev_led", 0, 8'h00, 1);
    expectAt("rev_wrap", 1, 8'h01, 1);
    expectAt("rev_wrap_end", 1, 8'h00, 2);
    step(1);
    applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
    step(1);

    // clr beats en; channel 1 keeps counting and wraps independently
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    step(1);
    applyStimulus(1'b1, 2'b11, 2'b00, 2'b00, 1'b0);
    expectAt("at40_led", 0, 8'hAA, 40);
    step(40);
    applyStimulus(1'b1, 2'b11, 2'b00, 2'b01, 1'b0);
    expectAt("clr_led", 0, 8'hA0, 1);
    expectAt("clr_wrap", 1, 8'h00, 1);
    step(1);
    applyStimulus(1'b1, 2'b11, 2'b00, 2'b00, 1'b0);
    expectAt("ch1_wrap_22", 1, 8'h00, 22);
    expectAt("ch1_wrap_23", 1, 8'h02, 23);
    expectAt("after_clr_led", 0, 8'h4A, 40);
    step(40);
    // Reset mid-count with snap requested: reset wins everywhere
    applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 1'b1);
    expectAt("midrst_led", 0, 8'h00, 1);
    expectAt("midrst_wrap", 1, 8'h00, 1);
    expectAt("midrst_snap_vld", 2, 8'h00, 1);
    expectAt("midrst_snap_q", 3, 8'h00, 1);
    step(1);
`endif

    // Snapshot at cnt0=12, cnt1=33
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    step(1);
    applyStimulus(1'b1, 2'b11, 2'b00, 2'b00, 1'b0);
    step(12);
    applyStimulus(1'b1, 2'b10, 2'b00, 2'b00, 1'b0);
    step(21);
    applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 1'b1);
    snap_exp.push_back(8'h83);
    expectAt("snap_vld_1", 2, 8'h01, 1);
    expectAt("snap_vld_0", 2, 8'h00, 2);
    expectAt("snap_q_held", 3, 8'h83, 2);
    step(1);
    applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
    step(1);

    // Held snap while counting captures pre-update values every cycle
    applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
    step(3);
    applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 1'b1);
    snap_exp.push_back(8'h83);
    snap_exp.push_back(8'h84);
    expectAt("snap_hold_vld_a", 2, 8'h01, 1);
    expectAt("snap_hold_vld_b", 2, 8'h01, 2);
    step(2);
    applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
    expectAt("snap_hold_vld_end", 2, 8'h00, 1);
    expectAt("snap_hold_q", 3, 8'h84, 1);
    expectAt("snap_hold_led", 0, 8'h84, 1);
    step(2);

`ifdef COUNTER_BANK_SATURATE_EN
    // Saturate at all-ones with a single pulse, then leave the limit downwards
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    step(1);
    applyStimulus(1'b1, 2'b01, 2'b00, 2'b00, 1'b0);
    expectAt("sat_wrap_62", 1, 8'h00, 62);
    expectAt("sat_wrap_63", 1, 8'h01, 63);
    expectAt("sat_wrap_64", 1, 8'h00, 64);
    expectAt("sat_wrap_70", 1, 8'h00, 70);
    expectAt("sat_led_70", 0, 8'h0F, 70);
    step(70);
    applyStimulus(1'b1, 2'b01, 2'b01, 2'b00, 1'b0);
    expectAt("sat_down_led", 0, 8'h0F, 1);
    expectAt("sat_down_wrap", 1, 8'h00, 1);
    expectAt("sat_down_led_4", 0, 8'h0E, 4);
    step(4);
    applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
    step(1);
`endif

    for (int i = 0; i < 100 && (pending.size() > 0 || snap_exp.size() > 0); i++) step(1);
    foreach (pending[i]) begin
      assertions++;
      failures++;
      $display("[TB] FAIL %s: check never reached, expected %h", pending[i].name, pending[i].exp);
    end
    foreach (snap_exp[i]) begin
      assertions++;
      failures++;
      $display("[TB] FAIL snap_missing: got no snap_vld, expected snap_q %h", snap_exp[i]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
